// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-bus access controller.
// Holds the ALU op-code bus width, the memory op codes, the FSM state
// encoding and small op-decode helpers used by the top and the aligner.
package mem_access_ctrl_pkg;

    localparam int ALUOP_BUS = 8;
    typedef logic [ALUOP_BUS-1:0] aluop_t;

    localparam aluop_t ALUOP_LB  = 8'h90;
    localparam aluop_t ALUOP_LBU = 8'h91;
    localparam aluop_t ALUOP_LH  = 8'h92;
    localparam aluop_t ALUOP_LHU = 8'h93;
    localparam aluop_t ALUOP_LW  = 8'h94;
    localparam aluop_t ALUOP_SB  = 8'h98;
    localparam aluop_t ALUOP_SH  = 8'h99;
    localparam aluop_t ALUOP_SW  = 8'h9A;

    typedef enum logic [2:0] {
        MEMST_IDLE  = 3'd0,
        MEMST_REQ   = 3'd1,
        MEMST_RESP  = 3'd2,
        MEMST_DONE  = 3'd3,
        MEMST_DRAIN = 3'd4
    } mem_state_t;

    function automatic logic is_load(input aluop_t op);
        return (op == ALUOP_LB) || (op == ALUOP_LBU) || (op == ALUOP_LH) ||
               (op == ALUOP_LHU) || (op == ALUOP_LW);
    endfunction

    function automatic logic is_store(input aluop_t op);
        return (op == ALUOP_SB) || (op == ALUOP_SH) || (op == ALUOP_SW);
    endfunction

    function automatic logic is_byte(input aluop_t op);
        return (op == ALUOP_LB) || (op == ALUOP_LBU) || (op == ALUOP_SB);
    endfunction

    function automatic logic is_half(input aluop_t op);
        return (op == ALUOP_LH) || (op == ALUOP_LHU) || (op == ALUOP_SH);
    endfunction

    function automatic logic is_word(input aluop_t op);
        return (op == ALUOP_LW) || (op == ALUOP_SW);
    endfunction

    // Halfwords need an even address, words a multiple of four.
    function automatic logic is_misaligned(input aluop_t op, input logic [1:0] addr_lo);
        return (is_half(op) && addr_lo[0]) || (is_word(op) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Byte-lane helper for the data bus (purely combinational).
//   op        : memory op code
//   addr_lo   : low two address bits
//   rdata     : raw bus read word
//   wdata     : right-justified store data
//   ldata     : selected load lane, sign- or zero-extended to 32 bits
//   lanes     : byte-lane mask (store write enables / load lanes read)
//   wdata_rep : store data replicated across all byte lanes
module mem_load_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [ALUOP_BUS-1:0] op,
    input  logic [1:0]           addr_lo,
    input  logic [31:0]          rdata,
    input  logic [31:0]          wdata,
    output logic [31:0]          ldata,
    output logic [3:0]           lanes,
    output logic [31:0]          wdata_rep
);

    logic [7:0]  rbyte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rbyte[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        sel_byte  = rbyte[addr_lo];
        sel_half  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        ldata     = 32'h0;
        lanes     = 4'b0000;
        wdata_rep = 32'h0;
        if (is_byte(op)) begin
            lanes     = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
            ldata     = (op == ALUOP_LB) ? {{24{sel_byte[7]}}, sel_byte} : {24'h0, sel_byte};
        end else if (is_half(op)) begin
            lanes     = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata[15:0]}};
            ldata     = (op == ALUOP_LH) ? {{16{sel_half[15]}}, sel_half} : {16'h0, sel_half};
        end else if (is_word(op)) begin
            lanes     = 4'b1111;
            wdata_rep = wdata;
            ldata     = rdata;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-bus access controller.
// Issues loads/stores on a req/gnt/rvalid bus, stalls the pipeline until the
// access completes, aligns load data, flags misalignment and bus timeouts.
//   cpu_clk_50M, cpu_rst        : clock, asynchronous active-high reset
//   mem_valid/aluop/addr/wdata  : instruction in the EXE/MEM slot
//   flush                       : pipeline flush (exception/eret)
//   dbus_*                      : data bus master side
//   stall_req                   : hold IF..MEM
//   mem_dreg/mem_dre            : aligned load result and lanes read
//   exc_adel/exc_ades           : load/store address error
//   exc_buserr                  : bus timeout, valid in DONE
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 8
) (
    input  logic                 cpu_clk_50M,
    input  logic                 cpu_rst,
    input  logic                 mem_valid,
    input  logic [ALUOP_BUS-1:0] mem_aluop,
    input  logic [31:0]          mem_addr,
    input  logic [31:0]          mem_wdata,
    input  logic                 flush,
    output logic                 dbus_req,
    output logic [3:0]           dbus_we,
    output logic [31:0]          dbus_addr,
    output logic [31:0]          dbus_wdata,
    input  logic                 dbus_gnt,
    input  logic                 dbus_rvalid,
    input  logic [31:0]          dbus_rdata,
    output logic                 stall_req,
    output logic [31:0]          mem_dreg,
    output logic [3:0]           mem_dre,
    output logic                 exc_adel,
    output logic                 exc_ades,
    output logic                 exc_buserr
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_t     state;
    logic [CNT_W-1:0] cnt;
    aluop_t         op_reg;
    logic [1:0]     addr_lo_reg;
    logic           store_reg;
    // A granted load that timed out still owes the bus a response.
    logic           drain_after_done_reg;

    logic   cur_load, cur_store, cur_mis, start, timeout;
    aluop_t align_op;
    logic [1:0]  align_addr_lo;
    logic [31:0] align_ldata, align_wdata_rep;
    logic [3:0]  align_lanes;

    assign cur_load  = is_load(mem_aluop);
    assign cur_store = is_store(mem_aluop);
    assign cur_mis   = is_misaligned(mem_aluop, mem_addr[1:0]);
    assign start     = mem_valid && (cur_load || cur_store) && !cur_mis && !flush;
    assign timeout   = (cnt == CNT_LAST);

    assign exc_adel = (state == MEMST_IDLE) && mem_valid && cur_load  && cur_mis;
    assign exc_ades = (state == MEMST_IDLE) && mem_valid && cur_store && cur_mis;

    // In IDLE the aligner works on the live op (store lanes/replication);
    // afterwards it works on the latched op so load alignment is stable.
    assign align_op      = (state == MEMST_IDLE) ? mem_aluop : op_reg;
    assign align_addr_lo = (state == MEMST_IDLE) ? mem_addr[1:0] : addr_lo_reg;

    mem_load_align u_align (
        .op        (align_op),
        .addr_lo   (align_addr_lo),
        .rdata     (dbus_rdata),
        .wdata     (mem_wdata),
        .ldata     (align_ldata),
        .lanes     (align_lanes),
        .wdata_rep (align_wdata_rep)
    );

    always_comb begin
        stall_req = 1'b0;
        case (state)
            MEMST_IDLE:  stall_req = start;
            MEMST_REQ,
            MEMST_RESP:  stall_req = !flush;
            MEMST_DRAIN: stall_req = mem_valid && (cur_load || cur_store) && !flush;
            default:     stall_req = 1'b0;
        endcase
    end

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            state                <= MEMST_IDLE;
            cnt                  <= '0;
            op_reg               <= '0;
            addr_lo_reg          <= 2'b00;
            store_reg            <= 1'b0;
            drain_after_done_reg <= 1'b0;
            dbus_req             <= 1'b0;
            dbus_we              <= 4'b0000;
            dbus_addr            <= 32'h0;
            dbus_wdata           <= 32'h0;
            mem_dreg             <= 32'h0;
            mem_dre              <= 4'b0000;
            exc_buserr           <= 1'b0;
        end else begin
            case (state)
                MEMST_IDLE: begin
                    if (start) begin
                        state                <= MEMST_REQ;
                        cnt                  <= '0;
                        op_reg               <= mem_aluop;
                        addr_lo_reg          <= mem_addr[1:0];
                        store_reg            <= cur_store;
                        drain_after_done_reg <= 1'b0;
                        dbus_req             <= 1'b1;
                        dbus_we              <= cur_store ? align_lanes : 4'b0000;
                        dbus_addr            <= {mem_addr[31:2], 2'b00};
                        dbus_wdata           <= align_wdata_rep;
                    end
                end
                MEMST_REQ: begin
                    cnt <= cnt + CNT_W'(1);
                    if (flush) begin
                        // A store granted on the flush edge has committed;
                        // a granted load must still have its response drained.
                        dbus_req <= 1'b0;
                        dbus_we  <= 4'b0000;
                        state    <= (dbus_gnt && !store_reg) ? MEMST_DRAIN : MEMST_IDLE;
                    end else if (dbus_gnt) begin
                        dbus_req <= 1'b0;
                        dbus_we  <= 4'b0000;
                        if (store_reg) begin
                            state      <= MEMST_DONE;
                            mem_dreg   <= 32'h0;
                            mem_dre    <= 4'b0000;
                            exc_buserr <= 1'b0;
                        end else begin
                            state <= MEMST_RESP;
                        end
                    end else if (timeout) begin
                        dbus_req   <= 1'b0;
                        dbus_we    <= 4'b0000;
                        state      <= MEMST_DONE;
                        mem_dreg   <= 32'h0;
                        mem_dre    <= 4'b0000;
                        exc_buserr <= 1'b1;
                    end
                end
                MEMST_RESP: begin
                    cnt <= cnt + CNT_W'(1);
                    if (flush) begin
                        state <= dbus_rvalid ? MEMST_IDLE : MEMST_DRAIN;
                    end else if (dbus_rvalid) begin
                        state      <= MEMST_DONE;
                        mem_dreg   <= align_ldata;
                        mem_dre    <= align_lanes;
                        exc_buserr <= 1'b0;
                    end else if (timeout) begin
                        state                <= MEMST_DONE;
                        mem_dreg             <= 32'h0;
                        mem_dre              <= 4'b0000;
                        exc_buserr           <= 1'b1;
                        drain_after_done_reg <= 1'b1;
                    end
                end
                MEMST_DONE: begin
                    exc_buserr           <= 1'b0;
                    drain_after_done_reg <= 1'b0;
                    state                <= drain_after_done_reg ? MEMST_DRAIN : MEMST_IDLE;
                end
                MEMST_DRAIN: begin
                    if (dbus_rvalid) begin
                        state <= MEMST_IDLE;
                    end
                end
                default: state <= MEMST_IDLE;
            endcase
        end
    end

endmodule
